// File: rtl/ex_muldiv_pkg.sv
// Shared funct codes, FSM state type and iteration count for the EX-stage
// multiply/divide sequencer.
package ex_muldiv_pkg;

  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  localparam int ITER_COUNT = 32;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned shift-add multiplier and, when MULDIV_DIV_EN is
// defined, the restoring divider. Both share the {upper, lower} working register.
module muldiv_step #(
  parameter int NBits = 32
) (
`ifdef MULDIV_DIV_EN
  input  logic               is_div,
`endif
  input  logic [2*NBits-1:0] acc,
  input  logic [NBits-1:0]   opnd,
  output logic [2*NBits-1:0] next_acc
);

  logic [NBits:0]       sum;
  logic [2*NBits-1:0]   mul_next;

  // Multiply: lower half holds the remaining multiplier bits, upper half the partial product.
  always_comb begin
    sum      = {1'b0, acc[2*NBits-1:NBits]} + {1'b0, opnd};
    mul_next = acc[0] ? {sum, acc[NBits-1:1]} : {1'b0, acc[2*NBits-1:1]};
  end

`ifdef MULDIV_DIV_EN
  logic [NBits:0]   partial;
  logic [NBits-1:0] diff;
  logic             fits;

  // Divide: upper half is the remainder, lower half shifts the dividend out and quotient in.
  always_comb begin
    partial = acc[2*NBits-1:NBits-1];
    fits    = partial >= {1'b0, opnd};
    diff    = partial[NBits-1:0] - opnd;
    if (!is_div) begin
      next_acc = mul_next;
    end else if (fits) begin
      next_acc = {diff, acc[NBits-2:0], 1'b1};
    end else begin
      next_acc = {acc[2*NBits-2:0], 1'b0};
    end
  end
`else
  assign next_acc = mul_next;
`endif

endmodule

// File: rtl/ex_muldiv_sequencer.sv
// EX-stage multi-cycle MULT/MULTU (and DIV/DIVU when MULDIV_DIV_EN is defined)
// sequencer that stalls the front of the pipeline and owns the HI/LO registers.
module ex_muldiv_sequencer
  import ex_muldiv_pkg::*;
#(
  parameter int NBits = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [5:0]       ALUFunction,
  input  logic [NBits-1:0] OperandA,
  input  logic [NBits-1:0] OperandB,
  output logic             Stall,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [NBits-1:0] HI,
  output logic [NBits-1:0] LO
);

  localparam logic [5:0] LastIter = 6'(ITER_COUNT - 1);

  muldiv_state_t      state, next_state;
  logic [5:0]         count;
  logic [2*NBits-1:0] acc, step_acc, final_acc;
  logic [NBits-1:0]   opnd;
  logic               op_div, sign_a, sign_b, div_zero;
  logic               is_mul_fn, is_div_fn, signed_fn, mul_div_op;
  logic               neg_a, neg_b, zero_divisor, last_iter;

  assign is_mul_fn = (ALUFunction == FUNCT_MULT) || (ALUFunction == FUNCT_MULTU);
`ifdef MULDIV_DIV_EN
  assign is_div_fn = (ALUFunction == FUNCT_DIV) || (ALUFunction == FUNCT_DIVU);
`else
  assign is_div_fn = 1'b0;
`endif
  assign signed_fn    = (ALUFunction == FUNCT_MULT) || (ALUFunction == FUNCT_DIV);
  assign mul_div_op   = Start && (is_mul_fn || is_div_fn);
  assign neg_a        = signed_fn && OperandA[NBits-1];
  assign neg_b        = signed_fn && OperandB[NBits-1];
  assign zero_divisor = is_div_fn && (OperandB == '0);
  assign last_iter    = (count == LastIter);
  assign Stall        = mul_div_op && (state != DONE);

  muldiv_step #(.NBits(NBits)) u_step (
`ifdef MULDIV_DIV_EN
    .is_div   (op_div),
`endif
    .acc      (acc),
    .opnd     (opnd),
    .next_acc (step_acc)
  );

  // The iterations run on magnitudes; the sign is restored on the last step.
  always_comb begin
    final_acc = step_acc;
    if (op_div) begin
      if (sign_a ^ sign_b) final_acc[NBits-1:0] = -step_acc[NBits-1:0];
      if (sign_a)          final_acc[2*NBits-1:NBits] = -step_acc[2*NBits-1:NBits];
    end else if (sign_a ^ sign_b) begin
      final_acc = -step_acc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    Busy       = 1'b0;
    Done       = 1'b0;
    DivByZero  = 1'b0;
    case (state)
      IDLE: begin
        if (mul_div_op) begin
          if (zero_divisor)   next_state = DONE;
          else if (is_div_fn) next_state = DIV;
          else                next_state = MUL;
        end
      end
      MUL, DIV: begin
        Busy = 1'b1;
        if (last_iter) next_state = DONE;
      end
      DONE: begin
        Done       = 1'b1;
        DivByZero  = div_zero;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= '0;
      acc      <= '0;
      opnd     <= '0;
      op_div   <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      div_zero <= 1'b0;
      HI       <= '0;
      LO       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mul_div_op) begin
            count    <= '0;
            acc      <= {{NBits{1'b0}}, (neg_a ? -OperandA : OperandA)};
            opnd     <= neg_b ? -OperandB : OperandB;
            op_div   <= is_div_fn;
            sign_a   <= neg_a;
            sign_b   <= neg_b;
            div_zero <= zero_divisor;
          end
        end
        MUL, DIV: begin
          count <= count + 6'd1;
          acc   <= last_iter ? final_acc : step_acc;
        end
        DONE: begin
          if (!div_zero) begin
            HI <= acc[2*NBits-1:NBits];
            LO <= acc[NBits-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Self-checking bench for ex_muldiv_sequencer: directed vector table, reset abort,
// back-to-back ops and randomized ops against an arithmetic reference model.
module tb_ex_muldiv_sequencer;
  import ex_muldiv_pkg::*;

`ifdef MULDIV_DIV_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [5:0]  ALUFunction;
  logic [31:0] OperandA, OperandB;
  logic        Stall, Busy, Done, DivByZero;
  logic [31:0] HI, LO;

  int          n_checks = 0;
  int          n_err = 0;
  logic [31:0] cur_hi = 32'h0;
  logic [31:0] cur_lo = 32'h0;

  ex_muldiv_sequencer #(.NBits(32)) dut (
    .clk(clk), .reset(reset), .Start(Start), .ALUFunction(ALUFunction),
    .OperandA(OperandA), .OperandB(OperandB), .Stall(Stall), .Busy(Busy),
    .Done(Done), .DivByZero(DivByZero), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic        acc;
    int          stalls;
    logic        dbz;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        chain;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Architectural result from plain arithmetic on the current HI/LO model state.
  function automatic void ref_model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                    output logic acc, output int st, output logic dz,
                                    output logic [31:0] hi, output logic [31:0] lo);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    acc = 1'b0; st = 0; dz = 1'b0; hi = cur_hi; lo = cur_lo;
    if (f == FUNCT_MULT || f == FUNCT_MULTU) begin
      acc = 1'b1; st = 33;
      if (f == FUNCT_MULTU) p = {32'h0, a} * {32'h0, b};
      else                  p = sa * sb;
      hi = p[63:32]; lo = p[31:0];
    end else if (DivEn && (f == FUNCT_DIV || f == FUNCT_DIVU)) begin
      acc = 1'b1;
      if (b == 32'h0) begin
        st = 1; dz = 1'b1;
      end else begin
        st = 33;
        if (f == FUNCT_DIVU) begin
          lo = a / b; hi = a % b;
        end else begin
          q = sa / sb; r = sa % sb;
          lo = q[31:0]; hi = r[31:0];
        end
      end
    end
  endfunction

  // Starts at posedge+1 and returns at posedge+1 just after the DONE edge.
  task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic exp_acc, input int exp_stalls, input logic exp_dbz,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input logic scramble);
    int   stalls;
    logic got_done, hold_ok;
    Start = 1'b1; ALUFunction = f; OperandA = a; OperandB = b;
    hold_ok = 1'b1;
    if (!exp_acc) begin
      repeat (4) begin
        @(negedge clk);
        if (Stall !== 1'b0 || Done !== 1'b0 || Busy !== 1'b0) hold_ok = 1'b0;
      end
      check({name, "/ignored"}, 64'(hold_ok), 64'(1));
      @(posedge clk); #1;
    end else begin
      stalls = 0; got_done = 1'b0;
      for (int c = 0; c < 80 && !got_done; c++) begin
        @(negedge clk);
        if (Done === 1'b1) begin
          got_done = 1'b1;
          check({name, "/dbz"}, 64'(DivByZero), 64'(exp_dbz));
          check({name, "/stall_in_done"}, 64'(Stall), 64'(0));
        end else begin
          if (Stall === 1'b1) stalls++;
          if (HI !== cur_hi || LO !== cur_lo) hold_ok = 1'b0;
          if (scramble && c == 1 && exp_stalls > 1) begin
            OperandA = $urandom; OperandB = $urandom;
            ALUFunction = ($urandom_range(0, 1) == 1) ? FUNCT_MULT : FUNCT_MULTU;
          end
        end
      end
      check({name, "/done_seen"}, 64'(got_done), 64'(1));
      check({name, "/stall_cycles"}, 64'(stalls), 64'(exp_stalls));
      check({name, "/hilo_held"}, 64'(hold_ok), 64'(1));
      @(posedge clk); #1;
    end
    check({name, "/HI"}, 64'(HI), 64'(exp_hi));
    check({name, "/LO"}, 64'(LO), 64'(exp_lo));
    cur_hi = exp_hi; cur_lo = exp_lo;
  endtask

  initial begin
    logic        e_acc, e_dz, is_div;
    int          e_st;
    logic [31:0] e_hi, e_lo, ra, rb;
    logic [5:0]  rf;

    tbl[0]  = '{FUNCT_MULTU, 32'h00000022, 32'h80000001, 1'b1, 33, 1'b0, 32'h00000011, 32'h00000022, 1'b0};
    tbl[1]  = '{FUNCT_DIVU,  32'h00000010, 32'h00000000, 1'b1, 1,  1'b1, 32'h00000011, 32'h00000022, 1'b0};
    tbl[2]  = '{FUNCT_MULTU, 32'hFFFFFFFF, 32'h00000002, 1'b1, 33, 1'b0, 32'h00000001, 32'hFFFFFFFE, 1'b0};
    tbl[3]  = '{FUNCT_MULT,  32'hFFFFFFFD, 32'h00000005, 1'b1, 33, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    tbl[4]  = '{FUNCT_DIV,   32'hFFFFFFF9, 32'h00000002, 1'b1, 33, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    tbl[5]  = '{FUNCT_DIVU,  32'h00000064, 32'h00000007, 1'b1, 33, 1'b0, 32'h00000002, 32'h0000000E, 1'b0};
    tbl[6]  = '{6'h20,       32'h00000001, 32'h00000002, 1'b0, 0,  1'b0, 32'h00000000, 32'h00000000, 1'b0};
    tbl[7]  = '{FUNCT_MULT,  32'h80000000, 32'h80000000, 1'b1, 33, 1'b0, 32'h40000000, 32'h00000000, 1'b0};
    tbl[8]  = '{FUNCT_DIV,   32'h00000007, 32'hFFFFFFFE, 1'b1, 33, 1'b0, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    tbl[9]  = '{FUNCT_MULTU, 32'h00000002, 32'h00000003, 1'b1, 33, 1'b0, 32'h00000000, 32'h00000006, 1'b1};
    tbl[10] = '{FUNCT_MULTU, 32'h00000004, 32'h00000005, 1'b1, 33, 1'b0, 32'h00000000, 32'h00000014, 1'b0};

    reset = 1'b1; Start = 1'b0; ALUFunction = 6'h0; OperandA = 32'h0; OperandB = 32'h0;
    #12;
    check("reset/Busy", 64'(Busy), 64'(0));
    check("reset/Done", 64'(Done), 64'(0));
    check("reset/DivByZero", 64'(DivByZero), 64'(0));
    check("reset/Stall", 64'(Stall), 64'(0));
    check("reset/HI", 64'(HI), 64'(0));
    check("reset/LO", 64'(LO), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      is_div = (tbl[i].f == FUNCT_DIV) || (tbl[i].f == FUNCT_DIVU);
      if (!tbl[i].acc || (is_div && !DivEn)) begin
        e_acc = 1'b0; e_st = 0; e_dz = 1'b0; e_hi = cur_hi; e_lo = cur_lo;
      end else begin
        e_acc = 1'b1; e_st = tbl[i].stalls; e_dz = tbl[i].dbz; e_hi = tbl[i].hi; e_lo = tbl[i].lo;
      end
      run_op($sformatf("vec%0d", i), tbl[i].f, tbl[i].a, tbl[i].b, e_acc, e_st, e_dz, e_hi, e_lo, 1'b0);
      if (!tbl[i].chain) begin
        Start = 1'b0;
        @(posedge clk); #1;
      end
    end

    // Reset in the middle of a MULT aborts it and clears HI/LO at once.
    Start = 1'b1; ALUFunction = FUNCT_MULT; OperandA = 32'h00012345; OperandB = 32'h00000777;
    repeat (12) @(negedge clk);
    check("abort/busy_before", 64'(Busy), 64'(1));
    #2 reset = 1'b1;
    #1;
    check("abort/Busy", 64'(Busy), 64'(0));
    check("abort/Done", 64'(Done), 64'(0));
    check("abort/HI", 64'(HI), 64'(0));
    check("abort/LO", 64'(LO), 64'(0));
    Start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    cur_hi = 32'h0; cur_lo = 32'h0;
    @(posedge clk); #1;
    run_op("post_reset", FUNCT_MULTU, 32'h3, 32'h4, 1'b1, 33, 1'b0, 32'h0, 32'hC, 1'b0);
    Start = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 4))
        0:       rf = FUNCT_MULT;
        1:       rf = FUNCT_MULTU;
        2:       rf = FUNCT_DIV;
        3:       rf = FUNCT_DIVU;
        default: rf = 6'h20;
      endcase
      ra = $urandom;
      if ($urandom_range(0, 5) == 0)      rb = 32'h0;
      else if ($urandom_range(0, 1) == 1) rb = $urandom;
      else                                rb = 32'($urandom_range(1, 255));
      ref_model(rf, ra, rb, e_acc, e_st, e_dz, e_hi, e_lo);
      run_op($sformatf("rand%0d", i), rf, ra, rb, e_acc, e_st, e_dz, e_hi, e_lo, 1'b1);
      Start = 1'b0;
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
